// File: rtl/tc_ps_acp_rd_if.sv
// ACP read-channel bundle (AR + R) between the burst reader and the PS coherent port.
interface tc_ps_acp_rd_if;
  logic [31:0] S_AXI_ACP_0_araddr;
  logic [1:0]  S_AXI_ACP_0_arburst;
  logic [3:0]  S_AXI_ACP_0_arcache;
  logic [2:0]  S_AXI_ACP_0_arid;
  logic [3:0]  S_AXI_ACP_0_arlen;
  logic [1:0]  S_AXI_ACP_0_arlock;
  logic [2:0]  S_AXI_ACP_0_arprot;
  logic [3:0]  S_AXI_ACP_0_arqos;
  logic [2:0]  S_AXI_ACP_0_arsize;
  logic [4:0]  S_AXI_ACP_0_aruser;
  logic        S_AXI_ACP_0_arvalid;
  logic        S_AXI_ACP_0_arready;
  logic [63:0] S_AXI_ACP_0_rdata;
  logic [2:0]  S_AXI_ACP_0_rid;
  logic [1:0]  S_AXI_ACP_0_rresp;
  logic        S_AXI_ACP_0_rlast;
  logic        S_AXI_ACP_0_rvalid;
  logic        S_AXI_ACP_0_rready;

  modport master (
    output S_AXI_ACP_0_araddr, S_AXI_ACP_0_arburst, S_AXI_ACP_0_arcache, S_AXI_ACP_0_arid,
           S_AXI_ACP_0_arlen, S_AXI_ACP_0_arlock, S_AXI_ACP_0_arprot, S_AXI_ACP_0_arqos,
           S_AXI_ACP_0_arsize, S_AXI_ACP_0_aruser, S_AXI_ACP_0_arvalid, S_AXI_ACP_0_rready,
    input  S_AXI_ACP_0_arready, S_AXI_ACP_0_rdata, S_AXI_ACP_0_rid, S_AXI_ACP_0_rresp,
           S_AXI_ACP_0_rlast, S_AXI_ACP_0_rvalid
  );

  modport slave (
    input  S_AXI_ACP_0_araddr, S_AXI_ACP_0_arburst, S_AXI_ACP_0_arcache, S_AXI_ACP_0_arid,
           S_AXI_ACP_0_arlen, S_AXI_ACP_0_arlock, S_AXI_ACP_0_arprot, S_AXI_ACP_0_arqos,
           S_AXI_ACP_0_arsize, S_AXI_ACP_0_aruser, S_AXI_ACP_0_arvalid, S_AXI_ACP_0_rready,
    output S_AXI_ACP_0_arready, S_AXI_ACP_0_rdata, S_AXI_ACP_0_rid, S_AXI_ACP_0_rresp,
           S_AXI_ACP_0_rlast, S_AXI_ACP_0_rvalid
  );
endinterface

// File: rtl/tc_ps_acp_rd.sv
// Single-burst coherent ACP reader: one INCR burst of BURST_LEN 64-bit beats per request.
// Optional macro ACP_RD_BEAT_CHK_EN adds rid/rlast consistency checks into rx_err.
module tc_ps_acp_rd #(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [3:0]  ARCACHE   = 4'b1111,
  parameter logic [4:0]  ARUSER    = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en,
  output logic        rx_rdy,
  input  logic [31:0] rx_araddr,
  input  logic [2:0]  rx_arid,
  input  logic        rx_stall,
  output logic [63:0] rx_rdata,
  output logic        rx_rdvalid,
  output logic        rx_rdlast,
  output logic        rx_done,
  output logic        rx_err,
  tc_ps_acp_rd_if.master acp
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic              arvalid_q;
  logic [CNT_W-1:0]  beat_cnt;

  logic accept_c;
  logic ar_fire_c;
  logic r_fire_c;
  logic last_beat_c;
  logic beat_err_c;
  logic rready_c;

  // Constant burst attributes: 64-bit INCR, normal non-locked, unprivileged access.
  assign acp.S_AXI_ACP_0_araddr  = addr_q;
  assign acp.S_AXI_ACP_0_arid    = id_q;
  assign acp.S_AXI_ACP_0_arvalid = arvalid_q;
  assign acp.S_AXI_ACP_0_arburst = 2'b01;
  assign acp.S_AXI_ACP_0_arsize  = 3'b011;
  assign acp.S_AXI_ACP_0_arlen   = LAST_BEAT;
  assign acp.S_AXI_ACP_0_arlock  = 2'b00;
  assign acp.S_AXI_ACP_0_arprot  = 3'b000;
  assign acp.S_AXI_ACP_0_arqos   = 4'b0000;
  assign acp.S_AXI_ACP_0_arcache = ARCACHE;
  assign acp.S_AXI_ACP_0_aruser  = ARUSER;

  // rready is gated by reset so no beat is taken in the cycle reset is applied.
  assign rready_c                = rst && (state == DATA) && !rx_stall;
  assign acp.S_AXI_ACP_0_rready  = rready_c;

  assign accept_c    = rx_en && rx_rdy;
  assign ar_fire_c   = arvalid_q && acp.S_AXI_ACP_0_arready;
  assign r_fire_c    = acp.S_AXI_ACP_0_rvalid && rready_c;
  assign last_beat_c = (beat_cnt == LAST_BEAT);

  // Per-beat error: response code, plus optional ID/last-flag consistency.
  always_comb begin
    beat_err_c = (acp.S_AXI_ACP_0_rresp != 2'b00);
`ifdef ACP_RD_BEAT_CHK_EN
    if (acp.S_AXI_ACP_0_rid != id_q) begin
      beat_err_c = 1'b1;
    end
    if (acp.S_AXI_ACP_0_rlast != last_beat_c) begin
      beat_err_c = 1'b1;
    end
`endif
  end

  // Next-state logic; the burst ends on the counted beat, never on rlast.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept_c) state_nxt = ADDR;
      ADDR: if (ar_fire_c) state_nxt = DATA;
      DATA: if (r_fire_c && last_beat_c) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      id_q       <= '0;
      arvalid_q  <= 1'b0;
      beat_cnt   <= '0;
      rx_rdy     <= 1'b0;
      rx_rdata   <= '0;
      rx_rdvalid <= 1'b0;
      rx_rdlast  <= 1'b0;
      rx_done    <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Ready only once the FSM has settled in IDLE for a full cycle.
      rx_rdy     <= (state == IDLE) && (state_nxt == IDLE);
      arvalid_q  <= (state_nxt == ADDR);
      rx_rdvalid <= r_fire_c;
      rx_rdlast  <= r_fire_c && last_beat_c;
      rx_done    <= (state == DONE);

      if (accept_c) begin
        addr_q <= rx_araddr & ADDR_MASK;
        id_q   <= rx_arid;
      end

      if (ar_fire_c) begin
        beat_cnt <= '0;
      end else if (r_fire_c) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end

      if (r_fire_c) begin
        rx_rdata <= acp.S_AXI_ACP_0_rdata;
      end

      // Sticky until the next accepted request.
      if (accept_c) begin
        rx_err <= 1'b0;
      end else if (r_fire_c && beat_err_c) begin
        rx_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tc_ps_acp_rd.md
TC_PS_ACP_RD -- requirements
Module: tc_ps_acp_rd

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, giving the beats per read burst (1..16); arlen = BURST_LEN-1.
REQ-002 SHALL have parameter ARCACHE, default 4'b1111, driven on S_AXI_ACP_0_arcache.
REQ-003 SHALL have parameter ARUSER, default 5'b11111, driven on S_AXI_ACP_0_aruser (coherent access).
REQ-004 SHALL have port clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  in  1  reset: synchronous, active-low.
REQ-006 SHALL have ports rx_en in 1 (request strobe), rx_rdy out 1 (idle, may accept request), rx_araddr in 32 (burst start byte address), rx_arid in 3 (transaction ID).
REQ-007 SHALL have ports rx_stall in 1 (user backpressure), rx_rdata out 64 (beat data), rx_rdvalid out 1 (beat strobe), rx_rdlast out 1 (final beat), rx_done out 1 (burst complete pulse), rx_err out 1 (error flag).
REQ-008 SHALL have ACP read ports S_AXI_ACP_0_ar{addr 32, burst 2, cache 4, id 3, len 4, lock 2, prot 3, qos 4, size 3, user 5, valid 1} out, arready in, r{data 64, id 3, resp 2, last 1, valid 1} in, rready out.

Function
REQ-009 SHALL implement FSM IDLE -> ADDR -> DATA -> DONE -> IDLE.
REQ-010 SHALL assert rx_rdy only in IDLE; rx_en with rx_rdy=1 latches rx_araddr (bits [2:0] forced 0) and rx_arid, then enters ADDR next cycle.
REQ-011 SHALL ignore rx_en outside IDLE.
REQ-012 SHALL drive arvalid=1 throughout ADDR, holding araddr/arid stable until arvalid&&arready, then enter DATA.
REQ-013 SHALL drive arburst=2'b01, arsize=3'b011, arlen=BURST_LEN-1, arlock=0, arprot=0, arqos=0 constantly.
REQ-014 SHALL drive rready = (state==DATA) && !rx_stall.
REQ-015 SHALL count beats with a 4-bit counter cleared on entering DATA, incremented on rvalid&&rready.
REQ-016 SHALL register each accepted beat: rx_rdata=rdata and rx_rdvalid=1 one cycle after the handshake; otherwise rx_rdvalid=0 and rx_rdata holds.
REQ-017 SHALL assert rx_rdlast with the rx_rdvalid of beat BURST_LEN-1.
REQ-018 SHALL move DATA -> DONE on the handshake of beat BURST_LEN-1, regardless of rlast.
REQ-019 SHALL pulse rx_done for exactly one cycle in DONE, then return to IDLE (rx_rdy=1 the following cycle).
REQ-020 SHALL give minimum request-to-request spacing of BURST_LEN+4 cycles with arready and rvalid tied high.
REQ-021 SHALL ignore rvalid outside DATA (rready=0).
REQ-022 SHALL set rx_err sticky on rresp!=2'b00 for any accepted beat; it is cleared only when a new request is accepted in IDLE.

Reset
REQ-023 SHALL, while rst=0, force state=IDLE, beat counter=0, arvalid=0, rready=0, rx_rdvalid=0, rx_rdlast=0, rx_done=0, rx_err=0, rx_rdata=0, latched address/ID=0.
REQ-024 SHALL hold rx_rdy=0 while rst=0 and set it to 1 on the first cycle after release.
REQ-025 SHALL abandon an in-flight burst on reset, with no rx_done and no further rx_rdvalid.

Configuration
REQ-026 SHALL, when ACP_RD_BEAT_CHK_EN is defined, also set rx_err on an accepted beat where rid != latched ID, or where rlast disagrees with (count==BURST_LEN-1).
REQ-027 SHALL, when ACP_RD_BEAT_CHK_EN is undefined, omit those checks, so rx_err reflects rresp only.

Verification
REQ-028 SHALL be verified by: rx_en, araddr=0x1000_0040, id=3, arready and rvalid always high -> one AR with araddr=0x1000_0040, arlen=15, arid=3; 16 rx_rdvalid pulses with rx_rdlast on the 16th; rx_done one cycle later.
REQ-029 SHALL be verified by: arready low for 5 cycles -> arvalid and araddr held stable for 6 cycles; no rready before the AR handshake.
REQ-030 SHALL be verified by: rx_stall high during beats 4-7 -> rready=0 for those cycles, no lost or duplicated beats, rx_rdata sequence 0..15 intact.
REQ-031 SHALL be verified by: rresp=2'b10 on beat 9 -> rx_err=1 until the next accepted rx_en; burst still completes with rx_done.
REQ-032 SHALL be verified by: with ACP_RD_BEAT_CHK_EN defined, rid=5 on beat 2 for arid=3 -> rx_err=1; the same stimulus without the macro -> rx_err=0.
REQ-033 SHALL be verified by: rst=0 at beat 7 -> all outputs at reset values next cycle, rx_rdy=1 after release, and a new request completes normally.
